// File: rtl/board_frame_ctrl.sv
// board_frame_ctrl: 640x480 raster timing generator plus the hand-off of the
// brick board from the game logic to the playing-screen renderer.
// Optional feature macro BOARD_DBUF_EN: when defined, offered boards are
// parked in a pending register and only published to the renderer at the
// last active pixel of a frame. Without it, boards pass straight through.
`ifndef BRICK_LEN
`define BRICK_LEN 3
`endif
`ifndef BOARD_SIZE
`define BOARD_SIZE (`BRICK_LEN*40)
`endif

module board_frame_ctrl #(
  parameter int BW       = `BOARD_SIZE,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
  input  logic          upd_valid,
  input  logic [BW-1:0] upd_board,
  output logic          upd_ready,
  output logic [BW-1:0] board_disp,
  output logic [9:0]    x_cnt,
  output logic [9:0]    y_cnt,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          commit,
  output logic          frame_start
);

  localparam logic [9:0] LP_H_MAX   = 10'(H_TOTAL - 1);
  localparam logic [9:0] LP_V_MAX   = 10'(V_TOTAL - 1);
  localparam logic [9:0] LP_H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] LP_HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] LP_HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] LP_VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] LP_VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [9:0]    w_x_nxt;
  logic [9:0]    w_y_nxt;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_video_on;
  logic          r_frame_start;
  logic [BW-1:0] r_board_disp;
  logic          r_commit;
  logic          r_upd_ready;
  logic          w_xfer;

  assign x_cnt       = r_x;
  assign y_cnt       = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign video_on    = r_video_on;
  assign frame_start = r_frame_start;
  assign board_disp  = r_board_disp;
  assign commit      = r_commit;
  assign upd_ready   = r_upd_ready;

  // A handshake completes on any clock edge, regardless of pix_en.
  assign w_xfer = upd_valid && r_upd_ready;

  // Next raster position: advance one pixel per pix_en tick, wrapping lines and frames.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (pix_en) begin
      if (r_x == LP_H_MAX) begin
        w_x_nxt = 10'd0;
        if (r_y == LP_V_MAX) begin
          w_y_nxt = 10'd0;
        end else begin
          w_y_nxt = r_y + 10'd1;
        end
      end else begin
        w_x_nxt = r_x + 10'd1;
        w_y_nxt = r_y;
      end
    end else begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
    end
  end

  // Counters and sync/blanking flags; the flags decode the next position so they line up with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= !((w_x_nxt >= LP_HS_BEG) && (w_x_nxt <= LP_HS_END));
      r_vsync       <= !((w_y_nxt >= LP_VS_BEG) && (w_y_nxt <= LP_VS_END));
      r_video_on    <= (w_x_nxt < LP_H_ACT) && (w_y_nxt < LP_V_ACT);
      r_frame_start <= pix_en && (w_x_nxt == 10'd0) && (w_y_nxt == 10'd0);
    end
  end

`ifdef BOARD_DBUF_EN

  localparam logic [9:0] LP_H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] LP_V_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } pend_state_t;

  pend_state_t   r_state;
  pend_state_t   w_state_nxt;
  logic [BW-1:0] r_pending;
  logic          w_commit_pt;
  logic          w_commit;

  // Last active pixel of the frame: loading here keeps the visible area stable.
  assign w_commit_pt = pix_en && (r_x == LP_H_LAST) && (r_y == LP_V_LAST);

  // Pending-slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pending-slot transitions: fill on a handshake, drain at the commit point.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_xfer) begin
          w_state_nxt = ST_HELD;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_HELD: begin
        if (w_commit_pt) begin
          w_state_nxt = ST_EMPTY;
          w_commit    = 1'b1;
        end else begin
          w_state_nxt = ST_HELD;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_commit    = 1'b0;
      end
    endcase
  end

  // Capture offers into the pending slot and publish it at the commit point; ready follows the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_board_disp <= '0;
      r_commit     <= 1'b0;
      r_upd_ready  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_pending <= upd_board;
      end
      if (w_commit) begin
        r_board_disp <= r_pending;
      end
      r_commit    <= w_commit;
      r_upd_ready <= (w_state_nxt == ST_EMPTY);
    end
  end

`else

  // Pass-through: every accepted board is shown immediately and announced with a commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_board_disp <= '0;
      r_commit     <= 1'b0;
      r_upd_ready  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_board_disp <= upd_board;
      end
      r_commit    <= w_xfer;
      r_upd_ready <= 1'b1;
    end
  end

`endif

endmodule

// File: tb/tb_board_frame_ctrl.sv
// Testbench for board_frame_ctrl: randomized board offers against a
// frame-arithmetic reference model and a commit scoreboard. Uses a reduced
// raster so several frames fit in a short run; follows BOARD_DBUF_EN.
module tb_board_frame_ctrl;

  localparam int BW  = 120;
  localparam int HA  = 16, HFP = 2, HS = 4, HBP = 2;
  localparam int VA  = 12, VFP = 2, VS = 2, VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;
  localparam int CP  = (VA - 1) * HT + (HA - 1);
  localparam int CLK_PER_FRAME = FT * 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_en;
  logic          upd_valid;
  logic [BW-1:0] upd_board;
  logic          upd_ready;
  logic [BW-1:0] board_disp;
  logic [9:0]    x_cnt, y_cnt;
  logic          hsync, vsync, video_on, commit, frame_start;

  board_frame_ctrl #(
    .BW(BW), .H_TOTAL(HT), .V_TOTAL(VT),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .upd_valid(upd_valid), .upd_board(upd_board), .upd_ready(upd_ready),
    .board_disp(board_disp), .x_cnt(x_cnt), .y_cnt(y_cnt),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .commit(commit), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [BW-1:0] sb_q[$];
  int   m_t;
  logic m_started, m_ready, m_held, m_exp_commit, m_fs;
  int   xfer_cnt;

  wire tb_xfer = upd_valid && upd_ready;
  wire at_cp   = pix_en && ((m_t % FT) == CP);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_board();
    logic [127:0] w;
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    return w[BW-1:0];
  endfunction

  // pix_en: one tick every 4th clock
  initial begin
    int cyc;
    cyc = 0;
    pix_en = 1'b0;
    forever begin
      @(negedge clk);
      pix_en = ((cyc % 4) == 3);
      cyc++;
    end
  end

  // Reference model: pixel tick count, expected handshake/commit behaviour, scoreboard push
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t          <= 0;
      m_started    <= 1'b0;
      m_ready      <= 1'b0;
      m_held       <= 1'b0;
      m_exp_commit <= 1'b0;
      m_fs         <= 1'b0;
      sb_q.delete();
    end else begin
      m_started <= 1'b1;
      if (tb_xfer) begin
        sb_q.push_back(upd_board);
        xfer_cnt <= xfer_cnt + 1;
      end
`ifdef BOARD_DBUF_EN
      m_exp_commit <= m_held && at_cp;
      m_held       <= (m_held && !at_cp) || tb_xfer;
      m_ready      <= !((m_held && !at_cp) || tb_xfer);
`else
      m_exp_commit <= tb_xfer;
      m_ready      <= 1'b1;
`endif
      m_fs <= pix_en && (((m_t + 1) % FT) == 0);
      if (pix_en) m_t <= m_t + 1;
    end
  end

  // Monitor: compare raster outputs every cycle, pop the scoreboard on each commit
  initial begin
    logic [BW-1:0] last_board, e;
    logic [9:0] ex, ey;
    logic ehs, evs, evo;
    last_board = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", {x_cnt, y_cnt, hsync, vsync, video_on, upd_ready, commit, frame_start},
            {20'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_board", board_disp, '0);
        last_board = '0;
      end else if (m_started) begin
        ex  = 10'(m_t % HT);
        ey  = 10'((m_t / HT) % VT);
        ehs = !((ex >= 10'(HA + HFP)) && (ex <= 10'(HA + HFP + HS - 1)));
        evs = !((ey >= 10'(VA + VFP)) && (ey <= 10'(VA + VFP + VS - 1)));
        evo = (ex < 10'(HA)) && (ey < 10'(VA));
        chk("timing", {x_cnt, y_cnt, hsync, vsync, video_on, frame_start},
            {ex, ey, ehs, evs, evo, m_fs});
        chk("upd_ready", upd_ready, m_ready);
        chk("commit", commit, m_exp_commit);
        if (commit) begin
          if (sb_q.size() == 0) begin
            chk("commit_unexpected", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("board_commit", board_disp, e);
            last_board = e;
          end
        end else begin
          chk("board_hold", board_disp, last_board);
        end
      end
    end
  end

  // Offer one board and hold it until accepted, bounded by a cycle budget
  task automatic offer(input logic [BW-1:0] b);
    int n0, k;
    upd_board = b;
    upd_valid = 1'b1;
    n0 = xfer_cnt;
    k  = 0;
    while (xfer_cnt == n0 && k < 3 * CLK_PER_FRAME) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (xfer_cnt == n0) begin
      n_err++;
      $display("FAIL offer_timeout: accepted %0d expected %0d", xfer_cnt - n0, 1);
    end
    upd_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    xfer_cnt  = 0;
    rst_n     = 1'b0;
    upd_valid = 1'b0;
    upd_board = '0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;

    // Idle frames: timing only, no commits
    repeat (2 * CLK_PER_FRAME) @(negedge clk);

    // Random offers, sometimes a second one right behind the first
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 1500)) @(negedge clk);
      offer(rand_board());
      if ($urandom_range(0, 1) == 1) offer(rand_board());
    end

    // Let everything drain, then offer and reset while it is pending
    repeat (2 * CLK_PER_FRAME) @(negedge clk);
    offer(rand_board());
    repeat ($urandom_range(10, 200)) @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Quiet frames after reset: board must stay cleared
    repeat (3 * CLK_PER_FRAME) @(negedge clk);
    chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    chk("final_board_zero", board_disp, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
